// File: rtl/mix_columns_iter.sv
// rtl/mix_columns_iter.sv - iterative AES MixColumns, one column per clock
//
// Accepts one 128-bit state on in_valid/in_ready. It mixes columns 0..3 in
// place on four consecutive clocks through a single column mixer. The result
// is held on out_data with out_valid until out_ready takes it.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   in_data is valid
//   in_ready   block is idle and can accept a state
//   in_data    128-bit state, byte s0 = [127:120], column c = [127-32c -: 32]
//   inv        (MIXCOL_INV_EN only) 1 = InvMixColumns, captured on accept
//   out_valid  out_data holds a completed result
//   out_ready  consumer accepts out_data
//   out_data   mixed state, same byte ordering as in_data
//
// Build option: define MIXCOL_INV_EN to add the inv port and inverse mixer.

module mix_columns_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
`ifdef MIXCOL_INV_EN
  input  logic         inv,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]   state;
  logic [1:0]   col_cnt;
  logic [127:0] work;
  logic [31:0]  col_in;
  logic [31:0]  col_out;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_fwd(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    // 3*x is written as xtime(x) ^ x
    mix_fwd[31:24] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    mix_fwd[23:16] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    mix_fwd[15:8]  = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    mix_fwd[7:0]   = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  endfunction

`ifdef MIXCOL_INV_EN
  logic inv_q;

  // Multiply by a 4-bit constant k using chained xtime (x, 2x, 4x, 8x).
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    gmul = (k[0] ? x : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [31:0] mix_inv(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    mix_inv[31:24] = gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9);
    mix_inv[23:16] = gmul(a0, 4'd9)  ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13);
    mix_inv[15:8]  = gmul(a0, 4'd13) ^ gmul(a1, 4'd9)  ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11);
    mix_inv[7:0]   = gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9)  ^ gmul(a3, 4'd14);
  endfunction
`endif

  // Select the column currently being processed.
  always_comb begin
    col_in = work[127:96];
    case (col_cnt)
      2'd0: col_in = work[127:96];
      2'd1: col_in = work[95:64];
      2'd2: col_in = work[63:32];
      2'd3: col_in = work[31:0];
      default: col_in = work[127:96];
    endcase
  end

  // The single shared column mixer.
  always_comb begin
`ifdef MIXCOL_INV_EN
    col_out = inv_q ? mix_inv(col_in) : mix_fwd(col_in);
`else
    col_out = mix_fwd(col_in);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      col_cnt <= 2'd0;
      work    <= 128'h0;
`ifdef MIXCOL_INV_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work    <= in_data;
            col_cnt <= 2'd0;
`ifdef MIXCOL_INV_EN
            inv_q   <= inv;
`endif
            state   <= BUSY;
          end
        end
        BUSY: begin
          case (col_cnt)
            2'd0: work[127:96] <= col_out;
            2'd1: work[95:64]  <= col_out;
            2'd2: work[63:32]  <= col_out;
            2'd3: work[31:0]   <= col_out;
            default: work[127:96] <= col_out;
          endcase
          col_cnt <= col_cnt + 2'd1;
          if (col_cnt == 2'd3) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = work;

endmodule

// File: tb/tb_mix_columns_iter.sv
// tb/tb_mix_columns_iter.sv - directed self-checking bench for mix_columns_iter

module tb_mix_columns_iter;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
`ifdef MIXCOL_INV_EN
  logic         inv_v;
`endif

  int tests;
  int fails;

  mix_columns_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef MIXCOL_INV_EN
    .inv       (inv_v),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] V1_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] V1_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] V2_IN  = 128'h49db873b453953897f02d2f177de961a;
  localparam logic [127:0] V2_OUT = 128'h584dcaf11b4b5aacdbe7caa81b6bb0e5;
  localparam logic [127:0] V3_IN  = 128'hacc1d6b8efb55a7b1323cfdf457311b5;
  localparam logic [127:0] V3_OUT = 128'h75ec0993200b633353c0cf7cbb25d0dc;

  // Drive one input handshake; assumes in_ready is high.
  task automatic send(input logic [127:0] din);
    in_valid = 1'b1;
    in_data  = din;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid; n = edges counted since the caller's point.
  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    tests++;
    if (out_data !== 128'h0) begin
      fails++; $display("FAIL reset_out_data: got %h want 0", out_data);
    end
  endtask

  task automatic test_forward();
    logic [127:0] vin [3];
    logic [127:0] vout[3];
    int n;
    vin[0] = V1_IN; vout[0] = V1_OUT;
    vin[1] = V2_IN; vout[1] = V2_OUT;
    vin[2] = V3_IN; vout[2] = V3_OUT;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (in_ready !== 1'b1) begin
        fails++; $display("FAIL fwd%0d_ready_before: got %b want 1", i, in_ready);
      end
      send(vin[i]);
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        fails++; $display("FAIL fwd%0d_after_accept: out_valid %b in_ready %b want 0 0", i, out_valid, in_ready);
      end
      wait_done(n);
      tests++;
      if (n !== 4) begin
        fails++; $display("FAIL fwd%0d_latency: got %0d edges want 4", i, n);
      end
      tests++;
      if (out_data !== vout[i]) begin
        fails++; $display("FAIL fwd%0d_data: got %h want %h", i, out_data, vout[i]);
      end
      take();
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        fails++; $display("FAIL fwd%0d_after_take: out_valid %b in_ready %b want 0 1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    send(V2_IN);
    // Corrupting in_data during BUSY, and offering a new state during DONE,
    // must not disturb the held result.
    in_data  = 128'hffffffffffffffffffffffffffffffff;
    wait_done(n);
    in_valid = 1'b1;
    tests++;
    if (n !== 4) begin
      fails++; $display("FAIL bp_latency: got %0d edges want 4", n);
    end
    for (int c = 0; c < 10; c++) begin
      tests++;
      if (out_valid !== 1'b1 || out_data !== V2_OUT || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold%0d: out_valid %b in_ready %b data %h want 1 0 %h", c, out_valid, in_ready, out_data, V2_OUT);
      end
      @(posedge clk); #1;
    end
    take();
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL bp_after_take: out_valid %b in_ready %b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    send(V3_IN);
    @(posedge clk); #1;
    // Now in the second BUSY cycle.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 128'h0) begin
      fails++;
      $display("FAIL rstmid_state: in_ready %b out_valid %b data %h want 1 0 0", in_ready, out_valid, out_data);
    end
    send(V1_IN);
    wait_done(n);
    tests++;
    if (n !== 4 || out_data !== V1_OUT) begin
      fails++; $display("FAIL rstmid_next: edges %0d data %h want 4 %h", n, out_data, V1_OUT);
    end
    take();
  endtask

  task automatic test_back_to_back();
    int acc_edge[2];
    logic [127:0] res[2];
    int acc_cnt;
    int res_cnt;
    logic r, v, iv;
    logic [127:0] d;
    acc_cnt = 0;
    res_cnt = 0;
    acc_edge[0] = 0; acc_edge[1] = 0;
    res[0] = '0; res[1] = '0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = V1_IN;
    for (int c = 1; c <= 30 && res_cnt < 2; c++) begin
      r = in_ready; v = out_valid; d = out_data; iv = in_valid;
      @(posedge clk); #1;
      if (iv && r && acc_cnt < 2) begin
        acc_edge[acc_cnt] = c;
        acc_cnt++;
        if (acc_cnt == 1) in_data = V2_IN;
        else in_valid = 1'b0;
      end
      if (v && res_cnt < 2) begin
        res[res_cnt] = d;
        res_cnt++;
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    tests++;
    if (acc_cnt !== 2 || (acc_edge[1] - acc_edge[0]) !== 6) begin
      fails++; $display("FAIL b2b_spacing: accepts %0d spacing %0d want 2 6", acc_cnt, acc_edge[1] - acc_edge[0]);
    end
    tests++;
    if (res[0] !== V1_OUT) begin
      fails++; $display("FAIL b2b_first: got %h want %h", res[0], V1_OUT);
    end
    tests++;
    if (res[1] !== V2_OUT) begin
      fails++; $display("FAIL b2b_second: got %h want %h", res[1], V2_OUT);
    end
  endtask

`ifdef MIXCOL_INV_EN
  task automatic test_inverse();
    int n;
    inv_v = 1'b1;
    send(V1_OUT);
    inv_v = 1'b0;
    wait_done(n);
    tests++;
    if (n !== 4 || out_data !== V1_IN) begin
      fails++; $display("FAIL inv1: edges %0d data %h want 4 %h", n, out_data, V1_IN);
    end
    take();
    inv_v = 1'b1;
    send(V3_OUT);
    inv_v = 1'b0;
    wait_done(n);
    tests++;
    if (n !== 4 || out_data !== V3_IN) begin
      fails++; $display("FAIL inv2: edges %0d data %h want 4 %h", n, out_data, V3_IN);
    end
    take();
  endtask
`endif

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 128'h0;
    out_ready = 1'b0;
`ifdef MIXCOL_INV_EN
    inv_v     = 1'b0;
`endif
    @(posedge clk); #1;
    test_reset();
    test_forward();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef MIXCOL_INV_EN
    test_inverse();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
